// File: rtl/cmp_sweep_checker.sv
// Self-test initiator for a 4-bit magnitude comparator: sweeps all {A,B} pairs and checks LEDR/HEX3.
// Define CMP_SWEEP_HEX_CHECK_EN to also require the HEX3 pattern to match.
module cmp_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic [9:0] dut_sw_o,
    input  logic [9:0] dut_ledr_i,
    input  logic [7:0] dut_hex3_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [8:0] err_count_o,
    output logic [7:0] first_fail_o,
    output logic       first_fail_valid_o
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [8:0] ErrMax = 9'd256;

    localparam logic [9:0] LedrEq = 10'b00_0000_0100;
    localparam logic [9:0] LedrLt = 10'b00_0000_0001;
    localparam logic [9:0] LedrGt = 10'b00_0000_0010;
    localparam logic [7:0] HexE = 8'h86;
    localparam logic [7:0] HexL = 8'hC7;
    localparam logic [7:0] HexBlank = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [7:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [8:0]      err_q, err_d;
    logic [7:0]      ff_q, ff_d;
    logic            ffv_q, ffv_d;
    logic            pass_q, pass_d;

    logic [3:0] vec_a, vec_b;
    logic [9:0] exp_ledr;
    logic [7:0] exp_hex;
    logic       mismatch;
    logic       last_vec;
    logic       settle_last;

    // Expected verdict for the vector currently on the switch bus
    always_comb begin
        vec_a = idx_q[7:4];
        vec_b = idx_q[3:0];
        exp_ledr = LedrGt;
        exp_hex = HexBlank;
        if (vec_a == vec_b) begin
            exp_ledr = LedrEq;
            exp_hex = HexE;
        end else if (vec_a < vec_b) begin
            exp_ledr = LedrLt;
            exp_hex = HexL;
        end
    end

`ifdef CMP_SWEEP_HEX_CHECK_EN
    assign mismatch = (dut_ledr_i != exp_ledr) || (dut_hex3_i != exp_hex);
`else
    logic unused_hex;
    assign unused_hex = ^{dut_hex3_i, exp_hex};
    assign mismatch = (dut_ledr_i != exp_ledr);
`endif

    assign last_vec = (idx_q == 8'hFF);
    assign settle_last = (cnt_q == CntLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = StSettle;
            StSettle: if (settle_last) state_d = StCheck;
            StCheck:  state_d = last_vec ? StDone : StSettle;
            StDone:   if (start_i) state_d = StSettle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q == StSettle) || (state_q == StCheck);
        done_o = (state_q == StDone);
    end

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        err_d = err_q;
        ff_d = ff_q;
        ffv_d = ffv_q;
        pass_d = pass_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    idx_d = 8'd0;
                    cnt_d = '0;
                    err_d = 9'd0;
                    ff_d = 8'd0;
                    ffv_d = 1'b0;
                    pass_d = 1'b0;
                end
            end
            StSettle: begin
                cnt_d = settle_last ? '0 : cnt_q + 1'b1;
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_q != ErrMax) err_d = err_q + 9'd1;
                    if (!ffv_q) begin
                        ff_d = idx_q;
                        ffv_d = 1'b1;
                    end
                end
                // pass must reflect the count including this final check
                if (last_vec) begin
                    pass_d = (err_d == 9'd0);
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= 8'd0;
            cnt_q <= '0;
            err_q <= 9'd0;
            ff_q <= 8'd0;
            ffv_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            ff_q <= ff_d;
            ffv_q <= ffv_d;
            pass_q <= pass_d;
        end
    end

    assign dut_sw_o = {2'b00, idx_q};
    assign pass_o = pass_q;
    assign err_count_o = err_q;
    assign first_fail_o = ff_q;
    assign first_fail_valid_o = ffv_q;

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Bench for cmp_sweep_checker: a faultable comparator model plus a per-vector reference of the verdicts.
module tb_cmp_sweep_checker;

    localparam int unsigned Settle = 4;
    localparam int SweepCycles = 256 * (Settle + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] dut_sw;
    logic [9:0] dut_ledr;
    logic [7:0] dut_hex3;
    logic       busy, done, pass, ffv;
    logic [8:0] err_count;
    logic [7:0] first_fail;

    int n_vec = 0;
    int n_err = 0;

    // 0 golden, 1 LEDR stuck 0, 2 fault at A=3 B=5, 3 HEX blank on A==B, 4 random faults
    int mode = 0;
    logic [9:0] rnd_ledr [256];
    logic [7:0] rnd_hex [256];

    cmp_sweep_checker #(.SETTLE_CYCLES(Settle)) u_dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_i            (start),
        .dut_sw_o           (dut_sw),
        .dut_ledr_i         (dut_ledr),
        .dut_hex3_i         (dut_hex3),
        .busy_o             (busy),
        .done_o             (done),
        .pass_o             (pass),
        .err_count_o        (err_count),
        .first_fail_o       (first_fail),
        .first_fail_valid_o (ffv)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] gold_l(input logic [7:0] v);
        if (v[7:4] == v[3:0]) return 10'h004;
        if (v[7:4] < v[3:0]) return 10'h001;
        return 10'h002;
    endfunction

    function automatic logic [7:0] gold_h(input logic [7:0] v);
        if (v[7:4] == v[3:0]) return 8'h86;
        if (v[7:4] < v[3:0]) return 8'hC7;
        return 8'hFF;
    endfunction

    function automatic logic [9:0] model_l(input logic [7:0] v);
        case (mode)
            1: return 10'h000;
            2: return (v == 8'h35) ? 10'h004 : gold_l(v);
            4: return rnd_ledr[v];
            default: return gold_l(v);
        endcase
    endfunction

    function automatic logic [7:0] model_h(input logic [7:0] v);
        case (mode)
            2: return (v == 8'h35) ? 8'h86 : gold_h(v);
            3: return (v[7:4] == v[3:0]) ? 8'hFF : gold_h(v);
            4: return rnd_hex[v];
            default: return gold_h(v);
        endcase
    endfunction

    // Comparator model responds half a cycle after each new vector
    always @(negedge clk) begin
        dut_ledr = model_l(dut_sw[7:0]);
        dut_hex3 = model_h(dut_sw[7:0]);
    end

    task automatic reference(output int errs, output int ff, output bit ffv_e);
        errs = 0;
        ff = 0;
        ffv_e = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            bit bad;
            v = i[7:0];
            bad = (model_l(v) != gold_l(v));
`ifdef CMP_SWEEP_HEX_CHECK_EN
            bad = bad || (model_h(v) != gold_h(v));
`endif
            if (bad) begin
                if (!ffv_e) begin
                    ffv_e = 1;
                    ff = i;
                end
                errs++;
            end
        end
    endtask

    // Runs one sweep; optionally re-pulses start at vector restart_at (must be ignored)
    task automatic run_sweep(input string name, input int restart_at);
        int n;
        int errs, ff;
        bit ffv_e;
        bit got;
        reference(errs, ff, ffv_e);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq({name, " busy_at_start"}, 32'(busy), 32'd1);
        check_eq({name, " sw_at_start"}, 32'(dut_sw), 32'd0);
        n = 0;
        got = 0;
        while (n < 3000 && !got) begin
            @(posedge clk);
            n++;
            #1;
            start = (restart_at >= 0 && n == restart_at * int'(Settle + 1)) ? 1'b1 : 1'b0;
            got = done;
        end
        start = 1'b0;
        check_eq({name, " done_latency"}, 32'(n), 32'(SweepCycles));
        check_eq({name, " busy_end"}, 32'(busy), 32'd0);
        check_eq({name, " pass"}, 32'(pass), 32'(errs == 0));
        check_eq({name, " err_count"}, 32'(err_count), 32'(errs));
        check_eq({name, " ffv"}, 32'(ffv), 32'(ffv_e));
        check_eq({name, " first_fail"}, 32'(first_fail), 32'(ff));
        repeat (6) @(posedge clk);
        #1;
        check_eq({name, " hold_done"}, 32'(done), 32'd1);
        check_eq({name, " hold_sw"}, 32'(dut_sw), 32'h0FF);
        check_eq({name, " hold_err"}, 32'(err_count), 32'(errs));
    endtask

    task automatic check_reset_state(input string name);
        check_eq({name, " sw"}, 32'(dut_sw), 32'd0);
        check_eq({name, " busy"}, 32'(busy), 32'd0);
        check_eq({name, " done"}, 32'(done), 32'd0);
        check_eq({name, " pass"}, 32'(pass), 32'd0);
        check_eq({name, " err"}, 32'(err_count), 32'd0);
        check_eq({name, " ff"}, 32'(first_fail), 32'd0);
        check_eq({name, " ffv"}, 32'(ffv), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        dut_ledr = 10'h000;
        dut_hex3 = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("idle_busy", 32'(busy), 32'd0);

        mode = 0;
        run_sweep("golden", -1);
        mode = 1;
        run_sweep("stuck0", -1);
        mode = 2;
        run_sweep("fault35", -1);
        mode = 3;
        run_sweep("hexblank", -1);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 256; i++) begin
                rnd_ledr[i] = gold_l(i[7:0]);
                rnd_hex[i] = gold_h(i[7:0]);
                if ($urandom_range(15) == 0) rnd_ledr[i] = rnd_ledr[i] ^ 10'($urandom_range(1023, 1));
                if ($urandom_range(15) == 0) rnd_hex[i] = rnd_hex[i] ^ 8'($urandom_range(255, 1));
            end
            mode = 4;
            run_sweep("random", -1);
        end

        // Reset in the middle of a sweep
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (dut_sw[7:0] != 8'd100 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("reach_idx100", 32'(dut_sw), 32'd100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("midreset");
        repeat (3) @(posedge clk);
        #1;
        check_eq("midreset_idle", 32'(busy), 32'd0);
        mode = 0;
        run_sweep("after_reset", -1);

        mode = 2;
        run_sweep("restart_ignored", 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
